sync_fifo_ext: RTL
==================

# sync_fifo_ext

Parametrised single-clock FIFO, successor to the basic synchronous FIFO. Adds:
- arbitrary (non-power-of-two) depth;
- selectable standard or first-word-fall-through (FWFT) read mode;
- programmable almost-full/almost-empty flags;
- sticky overflow/underflow error flags and a synchronous flush.

It sits between producer/consumer stages inside one clock domain and is the default buffering block for new datapaths.

## Interface
- DATA_WIDTH, 32, data bits per entry (>=1)
- DATA_DEPTH, 8, number of entries (>=2, any integer)
- FWFT, 0, 0 = standard read (data one cycle after rd_en), 1 = first-word-fall-through
- AF_TH, 6, almost_full_o asserted when count >= AF_TH (1..DATA_DEPTH)
- AE_TH, 2, almost_empty_o asserted when count <= AE_TH (0..DATA_DEPTH-1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush_i  in  1  synchronous clear of contents; error flags kept
- clr_err_i  in  1  clears overflow_o/underflow_o
- wr_en_i  in  1  write request
- wr_data_i  in  DATA_WIDTH  write data
- rd_en_i  in  1  read request (FWFT: acknowledge of head entry)
- rd_data_valid_o  out  1  rd_data_o holds valid data
- rd_data_o  out  DATA_WIDTH  read data
- elem_cnt_o  out  $clog2(DATA_DEPTH)+1  current occupancy, 0..DATA_DEPTH
- full_o, empty_o  out  1 each  count == DATA_DEPTH / count == 0
- almost_full_o, almost_empty_o  out  1 each  threshold flags
- overflow_o, underflow_o  out  1 each  sticky error flags

## Operation
- Reset values:
  - elem_cnt_o=0, empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0;
  - rd_data_valid_o=0, rd_data_o=0, overflow_o=0, underflow_o=0;
  - pointers=0.
- Memory contents are not reset.
- Read accepted (rd_acc) = rd_en_i & !empty_o.
- Write accepted (wr_acc) = wr_en_i & (!full_o | rd_acc). When full, a write is accepted in the same cycle as an accepted read.
- No empty bypass: a write into an empty FIFO is never readable in the same cycle.
- Pointers advance by 1 on acceptance and wrap DATA_DEPTH-1 -> 0. Occupancy is not derived from pointer MSBs.
- Count update:
  - +1 on wr_acc only;
  - -1 on rd_acc only;
  - unchanged on both or neither.
- Flag derivation: all status flags are derived from the registered count.
- Overflow/underflow:
  - wr_en_i & !wr_acc: write dropped, overflow_o <= 1;
  - rd_en_i & empty_o: underflow_o <= 1.
  - Both flags stay set until clr_err_i or rst. If clr_err_i coincides with a new error, the set wins.
- flush_i:
  - pointers and count go to 0; rd_data_valid_o <= 0;
  - overrides any wr_en_i/rd_en_i in the same cycle;
  - those requests are discarded without raising error flags.
- Priority: rst > flush_i > normal operation.
- Standard mode (FWFT=0):
  - on rd_acc, mem[rd_ptr] is registered into rd_data_o;
  - rd_data_valid_o=1 for exactly the following cycle, otherwise 0;
  - rd_data_o holds its last value when not valid.
- FWFT mode (FWFT=1):
  - rd_data_valid_o = !empty_o;
  - rd_data_o = mem[rd_ptr] whenever valid;
  - rd_en_i pops the presented entry, and the next entry (if any) is presented in the following cycle.

## Timing
- Write at edge N:
  - count, empty_o and full_o updated after edge N;
  - FWFT: data valid in cycle N+1.
- Standard read: rd_en_i sampled at edge N; data and valid present in cycle after edge N, i.e. sampled by the consumer at edge N+1. Read latency is 1 cycle.
- Throughput: one write and one read per cycle, sustained, at any occupancy including full and empty boundaries as defined above.
- Threshold flags change in the same cycle as elem_cnt_o. They have no extra latency and no hysteresis.
- rst or flush_i mid-burst: state cleared at that edge; the first request after deassertion is treated as on an empty FIFO.

## Test plan
- Reset and empty read:
  - Stimulus: rst for 2 cycles, then rd_en_i for 1 cycle.
  - Required: outputs at reset values; no valid data; underflow_o=1 after that edge; clr_err_i clears it to 0.
- Fill, overflow and drain (DATA_DEPTH=6, AF_TH=5, AE_TH=1, FWFT=0):
  - Stimulus: push 5..14 (10 writes), then pop 6.
  - Required: full_o after the 6th push; almost_full_o at count 5; overflow_o=1; pops return 5,6,7,8,9,10; empty_o=1 at the end.
- Wrap-around (depth 6):
  - Stimulus: repeat push 3 / pop 3 four times, values incrementing.
  - Required: data returned in order; elem_cnt_o never exceeds 3; no error flags.
- Simultaneous access:
  - Stimulus A: with FIFO full (6 entries), wr_en_i & rd_en_i together.
  - Required A: oldest entry returned, write accepted, count stays 6, overflow_o stays 0.
  - Stimulus B: with FIFO empty, wr_en_i & rd_en_i together.
  - Required B: underflow_o=1, count becomes 1.
- FWFT mode (FWFT=1):
  - Stimulus: push 23, then push 45 one cycle later; hold rd_en_i for 2 cycles.
  - Required: rd_data_valid_o rises the cycle after the first write with rd_data_o=23, then 45, then valid drops.
- Flush:
  - Stimulus: 4 entries stored, with overflow_o set; assert flush_i together with wr_en_i (value 99).
  - Required: count 0, empty_o=1, 99 not stored, overflow_o still 1.

Source files
------------

// File: rtl/sync_fifo_ext_if.sv
// Handshake and status bundle for sync_fifo_ext. The producer/consumer side uses
// the master modport and the FIFO uses the slave modport.
interface sync_fifo_ext_if #(
   parameter int DATA_WIDTH = 32,
   parameter int DATA_DEPTH = 8
);
   localparam int CNT_W = $clog2(DATA_DEPTH) + 1;

   logic                  flush_i;
   logic                  clr_err_i;
   logic                  wr_en_i;
   logic [DATA_WIDTH-1:0] wr_data_i;
   logic                  rd_en_i;
   logic                  rd_data_valid_o;
   logic [DATA_WIDTH-1:0] rd_data_o;
   logic [CNT_W-1:0]      elem_cnt_o;
   logic                  full_o;
   logic                  empty_o;
   logic                  almost_full_o;
   logic                  almost_empty_o;
   logic                  overflow_o;
   logic                  underflow_o;

   modport master (
      output flush_i, clr_err_i, wr_en_i, wr_data_i, rd_en_i,
      input  rd_data_valid_o, rd_data_o, elem_cnt_o, full_o, empty_o,
             almost_full_o, almost_empty_o, overflow_o, underflow_o
   );

   modport slave (
      input  flush_i, clr_err_i, wr_en_i, wr_data_i, rd_en_i,
      output rd_data_valid_o, rd_data_o, elem_cnt_o, full_o, empty_o,
             almost_full_o, almost_empty_o, overflow_o, underflow_o
   );
endinterface

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with arbitrary depth, standard or FWFT read, threshold flags,
// sticky overflow/underflow flags and a synchronous flush.
module sync_fifo_ext #(
   parameter int DATA_WIDTH = 32,
   parameter int DATA_DEPTH = 8,
   parameter bit FWFT       = 1'b0,
   parameter int AF_TH      = 6,
   parameter int AE_TH      = 2
) (
   input logic            clk,
   input logic            rst,
   sync_fifo_ext_if.slave bus
);
   localparam int CNT_W = $clog2(DATA_DEPTH) + 1;
   localparam int PTR_W = $clog2(DATA_DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DATA_DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      cnt;
   logic [CNT_W-1:0]      cnt_nxt;
   logic                  empty, full;
   logic                  rd_acc, wr_acc, rd_do, wr_do;
   logic                  ovf_set, unf_set;
   logic                  overflow_q, underflow_q;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (cnt == '0);
   assign full    = (cnt == CNT_W'(DATA_DEPTH));
   assign rd_acc  = bus.rd_en_i & ~empty;
   assign wr_acc  = bus.wr_en_i & (~full | rd_acc);
   // A flush swallows both requests and suppresses the error flags they would raise.
   assign rd_do   = rd_acc & ~bus.flush_i;
   assign wr_do   = wr_acc & ~bus.flush_i;
   assign ovf_set = bus.wr_en_i & ~wr_acc & ~bus.flush_i;
   assign unf_set = bus.rd_en_i & empty & ~bus.flush_i;

   always_comb begin
      // NOTE: assigning the default first keeps this purely combinational (no latch).
      cnt_nxt = cnt;
      if (wr_do && !rd_do)      cnt_nxt = cnt + 1'b1;
      else if (rd_do && !wr_do) cnt_nxt = cnt - 1'b1;
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         cnt         <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (bus.flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
         end else begin
            if (wr_do) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_do) rd_ptr <= ptr_inc(rd_ptr);
            cnt <= cnt_nxt;
         end
         if (ovf_set)            overflow_q  <= 1'b1;
         else if (bus.clr_err_i) overflow_q  <= 1'b0;
         if (unf_set)            underflow_q <= 1'b1;
         else if (bus.clr_err_i) underflow_q <= 1'b0;
      end
   end

   // NOTE: storage is deliberately not reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (!rst && wr_do) mem[wr_ptr] <= bus.wr_data_i;
   end

   if (FWFT) begin : g_fwft
      // Head entry is presented directly; zero while empty so stale storage never leaks.
      assign bus.rd_data_valid_o = ~empty;
      assign bus.rd_data_o       = empty ? '0 : mem[rd_ptr];
   end else begin : g_std
      logic                  valid_q;
      logic [DATA_WIDTH-1:0] data_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
         end else begin
            valid_q <= rd_do;
            if (rd_do) data_q <= mem[rd_ptr];
         end
      end

      assign bus.rd_data_valid_o = valid_q;
      assign bus.rd_data_o       = data_q;
   end

   assign bus.elem_cnt_o     = cnt;
   assign bus.empty_o        = empty;
   assign bus.full_o         = full;
   assign bus.almost_full_o  = (cnt >= CNT_W'(AF_TH));
   assign bus.almost_empty_o = (cnt <= CNT_W'(AE_TH));
   assign bus.overflow_o     = overflow_q;
   assign bus.underflow_o    = underflow_q;
endmodule
